// File: rtl/vmx_mm_sched_if.sv
// Host/engine/memory-side signal bundle of the vmx_mm job scheduler.
// VMX_SCHED_PERF_EN adds the last_cycles performance readout.
interface vmx_mm_sched_if #(
  parameter int QDEPTH = 4,
  parameter int AW     = 8,
  parameter int TAG_W  = 4,
  parameter int TO_W   = 16
);
  localparam int QW = $clog2(QDEPTH) + 1;

  logic             job_valid;
  logic             job_ready;
  logic [AW-1:0]    job_base;
  logic [TAG_W-1:0] job_tag;
  logic [TO_W-1:0]  timeout_lim;
  logic             abort;
  logic [31:0]      eng_ctrl;
  logic [31:0]      eng_flag;
  logic [AW-1:0]    eng_addr;
  logic             eng_wr_en;
  logic [AW-1:0]    mem_addr;
  logic             mem_wr_en;
  logic             done;
  logic [TAG_W-1:0] done_tag;
  logic             done_err;
  logic             busy;
  logic [QW-1:0]    q_count;
`ifdef VMX_SCHED_PERF_EN
  logic [31:0]      last_cycles;
`endif

  modport master (
    output job_valid, job_base, job_tag, timeout_lim, abort, eng_flag, eng_addr, eng_wr_en,
    input  job_ready, eng_ctrl, mem_addr, mem_wr_en, done, done_tag, done_err, busy, q_count
`ifdef VMX_SCHED_PERF_EN
    , input last_cycles
`endif
  );

  modport slave (
    input  job_valid, job_base, job_tag, timeout_lim, abort, eng_flag, eng_addr, eng_wr_en,
    output job_ready, eng_ctrl, mem_addr, mem_wr_en, done, done_tag, done_err, busy, q_count
`ifdef VMX_SCHED_PERF_EN
    , output last_cycles
`endif
  );
endinterface

// File: rtl/vmx_mm_sched.sv
// Job FIFO plus start/track/complete sequencer in front of the vmx_mm engine.
// VMX_SCHED_PERF_EN adds last_cycles (START..DONE span of the last good job).
module vmx_mm_sched #(
  parameter int QDEPTH    = 4,
  parameter int AW        = 8,
  parameter int TAG_W     = 4,
  parameter int TO_W      = 16,
  parameter int START_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  vmx_mm_sched_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int QW = PW + 1;

  // state     | meaning
  // IDLE      | no active job; launch FIFO head when present
  // START     | eng_ctrl[0] held for START_CYC cycles
  // WAIT_BUSY | waiting for engine flag to go nonzero
  // RUN       | engine busy, waiting for flag back to zero
  // DONE      | good completion pulse, pop head
  // ERR       | timeout/abort: abort request + error completion, pop head
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RUN, DONE, ERR} state_t;

  state_t           state;
  logic [AW-1:0]    base_mem [QDEPTH];
  logic [TAG_W-1:0] tag_mem  [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [QW-1:0]    count;
  logic [AW-1:0]    base_q;
  logic [TAG_W-1:0] tag_q;
  logic [TO_W-1:0]  cnt;
  logic             eng_start, eng_abort, done_q, done_err_q;
  logic [TAG_W-1:0] done_tag_q;
  logic             full, push, pop, active, flush_all, flush_keep;
  logic             eng_busy, stall, err_go;

  assign full       = (count == QW'(QDEPTH));
  assign push       = bus.job_valid & ~full & ~bus.abort;
  assign pop        = (state == DONE) || (state == ERR);
  assign active     = (state == START) || (state == WAIT_BUSY) || (state == RUN);
  assign flush_all  = bus.abort & ~active;
  assign flush_keep = bus.abort & active;
  assign eng_busy   = (bus.eng_flag != '0);
  assign stall      = ((state == WAIT_BUSY) && !eng_busy) || ((state == RUN) && eng_busy);
  assign err_go     = flush_keep || (stall && cnt == TO_W'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      base_mem[wr_ptr] <= bus.job_base;
      tag_mem[wr_ptr]  <= bus.job_tag;
    end
  end

  // On abort of an active job the head survives so ERR can report and pop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_all) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else if (flush_keep) begin
      wr_ptr <= rd_ptr + 1'b1;
      count  <= QW'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + QW'(push) - QW'(pop);
    end
  end

  // cnt is the START length and then the per-phase timeout down-counter (0 = never).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_tag_q <= '0;
    end else begin
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_tag_q <= '0;
      if (err_go) begin
        state      <= ERR;
        eng_abort  <= 1'b1;
        done_q     <= 1'b1;
        done_err_q <= 1'b1;
        done_tag_q <= tag_q;
      end else begin
        unique case (state)
          IDLE: if (count != '0 && !bus.abort) begin
            state     <= START;
            base_q    <= base_mem[rd_ptr];
            tag_q     <= tag_mem[rd_ptr];
            cnt       <= TO_W'(START_CYC);
            eng_start <= 1'b1;
          end
          START: if (cnt == TO_W'(1)) begin
            state <= WAIT_BUSY;
            cnt   <= bus.timeout_lim;
          end else begin
            cnt       <= cnt - 1'b1;
            eng_start <= 1'b1;
          end
          WAIT_BUSY: if (eng_busy) begin
            state <= RUN;
            cnt   <= bus.timeout_lim;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          RUN: if (!eng_busy) begin
            state      <= DONE;
            done_q     <= 1'b1;
            done_tag_q <= tag_q;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          DONE:    state <= IDLE;
          ERR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef VMX_SCHED_PERF_EN
  logic [31:0] perf_cnt, last_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt      <= '0;
      last_cycles_q <= '0;
    end else begin
      if (state == IDLE) perf_cnt <= 32'd1;
      else if (perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
      if (state == RUN && !eng_busy && !bus.abort)
        last_cycles_q <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
    end
  end

  assign bus.last_cycles = last_cycles_q;
`endif

  assign bus.job_ready = ~full;
  assign bus.eng_ctrl  = {30'd0, eng_abort, eng_start};
  assign bus.mem_addr  = (state == IDLE) ? bus.eng_addr : base_q + bus.eng_addr;
  assign bus.mem_wr_en = bus.eng_wr_en & ((state == WAIT_BUSY) || (state == RUN));
  assign bus.done      = done_q;
  assign bus.done_tag  = done_tag_q;
  assign bus.done_err  = done_err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.q_count   = count;
endmodule

// File: tb/tb_vmx_mm_sched.sv
// Directed + randomized bench for vmx_mm_sched against a queue-based job model.
// Build with VMX_SCHED_PERF_EN to also check last_cycles.
module tb_vmx_mm_sched;
  localparam int QDEPTH = 4, AW = 8, TAG_W = 4, TO_W = 16, START_CYC = 1;

  typedef struct {
    logic [7:0] base;
    logic [3:0] tag;
  } job_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  job_t mq[$];

  vmx_mm_sched_if #(.QDEPTH(QDEPTH), .AW(AW), .TAG_W(TAG_W), .TO_W(TO_W)) bus ();

  vmx_mm_sched #(.QDEPTH(QDEPTH), .AW(AW), .TAG_W(TAG_W), .TO_W(TO_W), .START_CYC(START_CYC))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic [3:0] t);
    bus.job_valid = 1'b1;
    bus.job_base  = b;
    bus.job_tag   = t;
    if (mq.size() < QDEPTH && !bus.abort) mq.push_back(job_t'{base: b, tag: t});
    tick();
    bus.job_valid = 1'b0;
  endtask

  // Engine model for the head job; pmode 1 pushes a job in the first engine cycle, 2 during DONE.
  task automatic run_engine(input int wait_c, input int run_c, input logic [7:0] first_addr,
                            input bit pattern1, input int pmode,
                            input logic [7:0] pb, input logic [3:0] pt);
    job_t hd;
    int n, span;
    logic [7:0] a;
    logic w;
    bit acc;
    hd = mq[0];
    n = 0;
    while (bus.eng_ctrl[0] !== 1'b1 && n < 40) begin tick(); n++; end
    chk("start_seen", {31'd0, bus.eng_ctrl[0]}, 32'd1);
    span = 1;
    n = 0;
    while (bus.eng_ctrl[0] === 1'b1 && n < 10) begin tick(); n++; span++; end
    chk("start_len", n, START_CYC);
    for (int i = 0; i < wait_c + run_c; i++) begin
      if (i < wait_c) bus.eng_flag = 32'd0;
      else if (pattern1) bus.eng_flag = (i - wait_c < 2) ? 32'd1 : 32'd2;
      else bus.eng_flag = $urandom | 32'd1;
      a = (i == 0) ? first_addr : 8'($urandom);
      w = (i == 0) ? 1'b1 : 1'($urandom);
      bus.eng_addr  = a;
      bus.eng_wr_en = w;
      if (i == 0 && pmode == 1) begin
        bus.job_valid = 1'b1;
        bus.job_base  = pb;
        bus.job_tag   = pt;
        if (mq.size() < QDEPTH) mq.push_back(job_t'{base: pb, tag: pt});
      end
      #1;
      chk("mem_addr", bus.mem_addr, (int'(hd.base) + int'(a)) % 256);
      chk("mem_wr_en", bus.mem_wr_en, w);
      tick();
      bus.job_valid = 1'b0;
      span++;
    end
    bus.eng_flag  = 32'd0;
    bus.eng_wr_en = 1'b1;
    n = 0;
    do begin tick(); n++; span++; end while (bus.done !== 1'b1 && n < 40);
    chk("done_lat", n, 1);
    chk("done_tag", bus.done_tag, hd.tag);
    chk("done_err", bus.done_err, 0);
    chk("done_wr_en", bus.mem_wr_en, 0);
    chk("done_qcnt", bus.q_count, mq.size());
`ifdef VMX_SCHED_PERF_EN
    chk("last_cycles", bus.last_cycles, span);
`endif
    acc = (mq.size() < QDEPTH);
    void'(mq.pop_front());
    if (pmode == 2) begin
      bus.job_valid = 1'b1;
      bus.job_base  = pb;
      bus.job_tag   = pt;
      if (acc) mq.push_back(job_t'{base: pb, tag: pt});
    end
    a = 8'($urandom);
    bus.eng_addr = a;
    tick();
    bus.job_valid = 1'b0;
    chk("done_pulse", bus.done, 0);
    chk("gap_busy", bus.busy, 0);
    chk("gap_wr_en", bus.mem_wr_en, 0);
    chk("gap_addr", bus.mem_addr, a);
    chk("gap_qcnt", bus.q_count, mq.size());
    bus.eng_wr_en = 1'b0;
  endtask

  initial begin
    int n, extra, pm;
    bit seen;
    job_t hd;
    bus.job_valid = 0; bus.job_base = '0; bus.job_tag = '0; bus.timeout_lim = '0;
    bus.abort = 0; bus.eng_flag = '0; bus.eng_addr = '0; bus.eng_wr_en = 0;

    // Reset values
    tick();
    chk("rst_ready", bus.job_ready, 1);
    chk("rst_qcnt", bus.q_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ctrl", bus.eng_ctrl, 0);
    chk("rst_done", {bus.done, bus.done_err, bus.done_tag}, 0);
    chk("rst_mem", {bus.mem_wr_en, bus.mem_addr}, 0);
`ifdef VMX_SCHED_PERF_EN
    chk("rst_perf", bus.last_cycles, 0);
`endif
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // Single job, flag 0 -> 1 (2) -> 2 (4) -> 0
    push(8'h00, 4'd3);
    run_engine(1, 6, 8'h05, 1'b1, 0, 8'h0, 4'h0);

    // Relocation incl. wrap-around
    push(8'h10, 4'd4);
    run_engine(1, 2, 8'h04, 1'b0, 0, 8'h0, 4'h0);
    push(8'hFE, 4'd5);
    run_engine(0, 3, 8'h03, 1'b0, 0, 8'h0, 4'h0);

    // Fill FIFO with an engine that never responds, refuse 5th, abort in WAIT_BUSY
    for (int i = 0; i < 4; i++) push(8'($urandom), 4'(8 + i));
    chk("full_qcnt", bus.q_count, mq.size());
    chk("full_ready", bus.job_ready, 0);
    push(8'h77, 4'd15);
    chk("refuse_qcnt", bus.q_count, 4);
    hd = mq[0];
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab1_done", {bus.done, bus.done_err}, 2'b11);
    chk("ab1_tag", bus.done_tag, hd.tag);
    chk("ab1_ctrl", bus.eng_ctrl, 32'd2);
    mq.delete();
    tick();
    chk("ab1_qcnt", bus.q_count, 0);
    chk("ab1_busy", bus.busy, 0);

    // Abort in IDLE refuses pushes
    bus.abort = 1'b1;
    push(8'h12, 4'd1);
    bus.abort = 1'b0;
    tick();
    chk("idle_abort_qcnt", bus.q_count, mq.size());
    chk("idle_abort_busy", bus.busy, 0);

    // Push and pop in the same cycle at count 2
    push(8'h40, 4'd6);
    push(8'h50, 4'd7);
    run_engine(2, 2, 8'h01, 1'b0, 2, 8'h60, 4'd8);
    chk("pp_qcnt", bus.q_count, 2);
    run_engine(1, 3, 8'h02, 1'b0, 0, 8'h0, 4'h0);
    run_engine(0, 1, 8'h03, 1'b0, 0, 8'h0, 4'h0);

    // Timeout in WAIT_BUSY after timeout_lim cycles, next job then runs
    bus.timeout_lim = 16'd8;
    push(8'h20, 4'd5);
    push(8'h30, 4'd6);
    n = 0;
    while (bus.eng_ctrl[0] !== 1'b1 && n < 40) begin tick(); n++; end
    tick();
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin tick(); n++; end
    chk("tmo_lat", n, 8);
    chk("tmo_ctrl", bus.eng_ctrl, 32'd2);
    chk("tmo_err", bus.done_err, 1);
    chk("tmo_tag", bus.done_tag, 4'd5);
    void'(mq.pop_front());
    tick();
    chk("tmo_pulse", {bus.eng_ctrl[1], bus.done}, 0);
    run_engine(2, 3, 8'h09, 1'b0, 0, 8'h0, 4'h0);
    bus.timeout_lim = '0;

    // Three jobs, abort during RUN of the first
    push(8'h01, 4'd9);
    push(8'h02, 4'd10);
    push(8'h03, 4'd11);
    bus.eng_flag = 32'd5;
    tick();
    tick();
    tick();
    chk("run_busy", bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.eng_flag = 32'd0;
    chk("ab2_done", {bus.done, bus.done_err}, 2'b11);
    chk("ab2_tag", bus.done_tag, 4'd9);
    mq.delete();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.eng_ctrl[0] === 1'b1 || bus.done === 1'b1) seen = 1'b1;
    end
    chk("ab2_quiet", seen, 0);
    chk("ab2_qcnt", bus.q_count, 0);

    // Tags 1,2,3 back-to-back
    push(8'($urandom), 4'd1);
    push(8'($urandom), 4'd2);
    run_engine(1, 2, 8'($urandom), 1'b0, 1, 8'($urandom), 4'd3);
    run_engine(0, 2, 8'($urandom), 1'b0, 0, 8'h0, 4'h0);
    run_engine(2, 1, 8'($urandom), 1'b0, 0, 8'h0, 4'h0);

    // Randomized rounds
    for (int r = 0; r < 5; r++) begin
      bus.timeout_lim = ($urandom_range(0, 1) == 1) ? 16'd20 : 16'd0;
      push(8'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) push(8'($urandom), 4'($urandom));
      extra = $urandom_range(0, 3);
      while (mq.size() > 0) begin
        pm = (extra > 0) ? $urandom_range(0, 2) : 0;
        if (pm != 0) extra--;
        run_engine($urandom_range(0, 5), $urandom_range(1, 6), 8'($urandom), 1'b0,
                   pm, 8'($urandom), 4'($urandom));
      end
    end

    // Reset mid-job drops it without a completion
    push(8'h33, 4'd12);
    bus.eng_flag = 32'd1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_qcnt", bus.q_count, 0);
    chk("mid_rst_ctrl", bus.eng_ctrl, 0);
    mq.delete();
    tick();
    rst_n = 1'b1;
    bus.eng_flag = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    chk("mid_rst_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
